// File: rtl/mesh_tap_scheduler_if.sv
// Bundle of the scheduler's datapath-facing signals: the weight RAM read
// port, the tile streamer handshake, the mesh control/weight broadcast and
// the result valid/ready port.
//   master : scheduler side (drives strobes, address, enables, weight, out_valid)
//   slave  : environment side (drives w_data, in_valid, out_ready)
interface mesh_tap_scheduler_if #(
  parameter int WEIGHT_BIT = 8,
  parameter int ADDR_W     = 10
) ();
  logic                  w_rd;
  logic [ADDR_W-1:0]     w_addr;
  logic [WEIGHT_BIT-1:0] w_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mesh_ena;
  logic                  mesh_clr;
  logic [WEIGHT_BIT-1:0] mesh_weight;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output w_rd, w_addr, in_ready, mesh_ena, mesh_clr, mesh_weight, out_valid,
    input  w_data, in_valid, out_ready
  );

  modport slave (
    input  w_rd, w_addr, in_ready, mesh_ena, mesh_clr, mesh_weight, out_valid,
    output w_data, in_valid, out_ready
  );
endinterface

// File: rtl/mesh_tap_scheduler.sv
// Sequences one accumulation pass of the MAC mesh: clears the accumulators,
// fetches one broadcast weight per kernel tap, pairs it with one input tile
// per tap, then presents the finished mesh result on a valid/ready port.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       pass start (IDLE only) / synchronous abort (any state)
//   cfg_taps, cfg_base taps per pass and weight address of tap 0, latched on start
//   busy, done         state != IDLE / one-cycle end-of-pass pulse
//   bus (master)       weight RAM read, tile handshake, mesh control, result port
module mesh_tap_scheduler #(
  parameter int WEIGHT_BIT = 8,
  parameter int CNT_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int MAC_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_taps,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              busy,
  output logic              done,
  mesh_tap_scheduler_if.master bus
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, RUN, DRAIN, OUT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      taps_q, taps_d;
  logic [CNT_W-1:0]      tap_q, tap_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [WEIGHT_BIT-1:0] weight_q, weight_d;
  logic                  done_q, done_d;

  logic fire;
  logic last;

  assign fire = (state_q == RUN) && bus.in_valid;
  assign last = (tap_q == taps_q - 1'b1);

  // The read for tap k+1 is issued in the cycle tap k fires, so its data is
  // on w_data during the following FETCH cycle. w_addr therefore runs one
  // tap ahead: it advances on the FETCH edge unless this is the last tap.
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign bus.w_rd        = (state_q == CLEAR) || (fire && !last);
  assign bus.w_addr      = waddr_q;
  assign bus.in_ready    = (state_q == RUN);
  assign bus.mesh_ena    = fire;
  assign bus.mesh_clr    = (state_q == CLEAR);
  assign bus.mesh_weight = weight_q;
  assign bus.out_valid   = (state_q == OUT);

  always_comb begin
    state_d  = state_q;
    taps_d   = taps_q;
    tap_d    = tap_q;
    drain_d  = drain_q;
    waddr_d  = waddr_q;
    weight_d = weight_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_taps != '0) begin
            taps_d  = cfg_taps;
            tap_d   = '0;
            waddr_d = cfg_base;
            state_d = CLEAR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = FETCH;
      FETCH: begin
        weight_d = bus.w_data;
        if (!last) waddr_d = waddr_q + 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (fire) begin
          tap_d = tap_q + 1'b1;
          if (last) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(MAC_LAT - 1)) state_d = OUT;
        else                                drain_d = drain_q + 1'b1;
      end
      OUT: begin
        if (bus.out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      taps_d   = '0;
      tap_d    = '0;
      drain_d  = '0;
      waddr_d  = '0;
      weight_d = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      taps_q   <= '0;
      tap_q    <= '0;
      drain_q  <= '0;
      waddr_q  <= '0;
      weight_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      tap_q    <= tap_d;
      drain_q  <= drain_d;
      waddr_q  <= waddr_d;
      weight_q <= weight_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mesh_tap_scheduler.sv
module tb_mesh_tap_scheduler;
  localparam int WB   = 8;
  localparam int CW   = 8;
  localparam int AW   = 10;
  localparam int ML   = 1;
  localparam int MAXT = 512;
  localparam int DEP  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_taps = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          busy, done;

  mesh_tap_scheduler_if #(.WEIGHT_BIT(WB), .ADDR_W(AW)) bus ();

  mesh_tap_scheduler #(
    .WEIGHT_BIT(WB), .CNT_W(CW), .ADDR_W(AW), .MAC_LAT(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_taps(cfg_taps), .cfg_base(cfg_base), .busy(busy), .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Weight RAM: data valid exactly one cycle after w_rd, garbage otherwise.
  logic [WB-1:0] mem [DEP];
  always @(posedge clk) begin
    if (bus.w_rd) bus.w_data <= mem[bus.w_addr];
    else          bus.w_data <= WB'($urandom);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle expectations for one pass; cycle 0 is the cycle start is driven.
  bit            e_busy [MAXT];
  bit            e_done [MAXT];
  bit            e_rd   [MAXT];
  bit            e_clr  [MAXT];
  bit            e_ena  [MAXT];
  bit            e_run  [MAXT];
  bit            e_ov   [MAXT];
  logic [AW-1:0] e_addr [MAXT];
  logic [WB-1:0] e_w    [MAXT];
  bit            v      [MAXT];

  // ab: -1 no abort, -2 abort at a random busy cycle, >=0 abort in that cycle.
  task automatic run_pass(input int taps, input int base, input int vmode,
                          input int rdly, input int ab_in, input bit stray);
    int t, done_t, out_start, t_end, ab;
    for (int i = 0; i < MAXT; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_clr[i] = 0; e_ena[i] = 0;
      e_run[i] = 0; e_ov[i] = 0; e_addr[i] = '0; e_w[i] = '0;
      case (vmode)
        0:       v[i] = 1;
        1:       v[i] = (i % 2 == 0);
        default: v[i] = ($urandom_range(0, 1) == 1) || (i % 4 == 0);
      endcase
    end
    done_t = -1;
    out_start = 0;
    ab = ab_in;
    if (ab != 0) begin
      if (taps == 0) begin
        done_t = 1;
        e_done[1] = 1;
      end else begin
        e_clr[1] = 1; e_rd[1] = 1; e_addr[1] = AW'(base);
        t = 2;
        for (int k = 0; k < taps; k++) begin
          t++;                                    // FETCH cycle
          while (!v[t]) begin
            e_run[t] = 1; e_w[t] = mem[(base + k) % DEP]; t++;
          end
          e_run[t] = 1; e_w[t] = mem[(base + k) % DEP]; e_ena[t] = 1;
          if (k < taps - 1) begin
            e_rd[t] = 1; e_addr[t] = AW'((base + k + 1) % DEP);
          end
          t++;
        end
        t += ML;
        out_start = t;
        t += rdly;
        for (int i = out_start; i <= t; i++) e_ov[i] = 1;
        done_t = t + 1;
        e_done[done_t] = 1;
        for (int i = 1; i < done_t; i++) e_busy[i] = 1;
      end
    end
    if (ab == -2) ab = (done_t > 1) ? $urandom_range(1, done_t - 1) : -1;
    if (ab >= 0) begin
      for (int i = ab + 1; i < MAXT; i++) begin
        e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_clr[i] = 0;
        e_ena[i] = 0; e_run[i] = 0; e_ov[i] = 0;
      end
    end
    t_end = ((done_t > ab) ? done_t : ab) + 4;

    for (int c = 0; c <= t_end; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        start = 1'b1; cfg_taps = CW'(taps); cfg_base = AW'(base);
      end else begin
        start = stray && e_busy[c] && ($urandom_range(0, 3) == 0);
        cfg_taps = CW'($urandom); cfg_base = AW'($urandom);
      end
      abort        = (c == ab);
      bus.in_valid = v[c];
      bus.out_ready = (c >= out_start + rdly);
      #2;
      chk($sformatf("busy@%0d", c),      busy,          e_busy[c]);
      chk($sformatf("done@%0d", c),      done,          e_done[c]);
      chk($sformatf("w_rd@%0d", c),      bus.w_rd,      e_rd[c]);
      chk($sformatf("mesh_clr@%0d", c),  bus.mesh_clr,  e_clr[c]);
      chk($sformatf("mesh_ena@%0d", c),  bus.mesh_ena,  e_ena[c]);
      chk($sformatf("in_ready@%0d", c),  bus.in_ready,  e_run[c]);
      chk($sformatf("out_valid@%0d", c), bus.out_valid, e_ov[c]);
      if (e_rd[c])  chk($sformatf("w_addr@%0d", c),      bus.w_addr,      e_addr[c]);
      if (e_run[c]) chk($sformatf("mesh_weight@%0d", c), bus.mesh_weight, e_w[c]);
      if (ab >= 0 && c > ab) begin
        chk($sformatf("abort_w_addr@%0d", c), bus.w_addr,      '0);
        chk($sformatf("abort_weight@%0d", c), bus.mesh_weight, '0);
      end
    end
    start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},     busy,            0);
    chk({tag, "_done"},     done,            0);
    chk({tag, "_w_rd"},     bus.w_rd,        0);
    chk({tag, "_w_addr"},   bus.w_addr,      0);
    chk({tag, "_in_ready"}, bus.in_ready,    0);
    chk({tag, "_ena"},      bus.mesh_ena,    0);
    chk({tag, "_clr"},      bus.mesh_clr,    0);
    chk({tag, "_weight"},   bus.mesh_weight, 0);
    chk({tag, "_out_vld"},  bus.out_valid,   0);
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) mem[i] = WB'($urandom);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_pass(3, 'h010, 0, 0, -1, 0);                 // basic pass, done at cycle 10
    run_pass(4, $urandom_range(0, DEP - 1), 1, 0, -1, 0); // toggling in_valid
    run_pass(4, 'h3FE, 0, 0, -1, 0);                 // address wrap
    run_pass(3, $urandom_range(0, DEP - 1), 0, 5, -1, 1); // OUT backpressure, stray starts
    run_pass(5, $urandom_range(0, DEP - 1), 0, 0, 5, 0);  // abort during tap 2 of 5
    run_pass(5, $urandom_range(0, DEP - 1), 0, 0, -1, 0); // clean pass after abort
    run_pass(0, $urandom_range(0, DEP - 1), 0, 0, -1, 0); // zero taps
    run_pass(3, $urandom_range(0, DEP - 1), 0, 0, 0, 0);  // abort with start in IDLE

    for (int p = 0; p < 14; p++) begin
      run_pass($urandom_range(1, 20), $urandom_range(0, DEP - 1), $urandom_range(0, 2),
               $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? -2 : -1,
               1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a pass behaves like power-on reset.
    @(posedge clk); #1;
    start = 1'b1; cfg_taps = 8'd6; cfg_base = 10'h123; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    run_pass(2, $urandom_range(0, DEP - 1), 2, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
